// File: rtl/fht_frame_ctrl.sv
// Frame sequencer in front of fht_top: loads N samples into the four FHT banks, starts the FHT,
// waits for ready and streams the N result words out. Optional macro FHT_FRAME_DROP_EN adds oDROP_CNT.
module fht_frame_ctrl #(
    parameter int N      = 1024,
    parameter int A_W    = 8,
    parameter int D_W    = 16,
    parameter int RD_LAT = 2,
    parameter int GUARD  = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_W-2:0]   iS_DATA,
    input  logic             iS_VALID,
    output logic             oS_READY,
    output logic [D_W-2:0]   oFHT_DATA,
    output logic [A_W-1:0]   oFHT_ADDR_WR,
    output logic [3:0]       oFHT_WE,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [A_W-1:0]   oFHT_ADDR_RD,
    input  logic [D_W-1:0]   iFHT_DATA_0,
    input  logic [D_W-1:0]   iFHT_DATA_1,
    input  logic [D_W-1:0]   iFHT_DATA_2,
    input  logic [D_W-1:0]   iFHT_DATA_3,
    output logic [D_W-1:0]   oM_DATA,
    output logic             oM_VALID,
    output logic             oM_LAST,
    output logic             oBUSY
`ifdef FHT_FRAME_DROP_EN
    ,
    output logic [15:0]      oDROP_CNT
`endif
);

    // state   | meaning
    // LOAD    | accept samples, write them into the banks
    // START   | start pulse, coincident with the last write
    // GUARD   | ignore ready for GUARD cycles after start
    // WAIT    | wait for FHT ready
    // READ    | issue N read addresses
    // DRAIN   | let the read pipeline empty up to the last word

    localparam int LOG_N = A_W + 2;
`ifdef FHT_FRAME_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_LOAD, S_START, S_GUARD, S_WAIT, S_READ, S_DRAIN} state_t;

    state_t           state;
    logic [LOG_N-1:0] s;
    logic [LOG_N-1:0] r;
    logic [7:0]       guard_cnt;
    logic [RD_LAT-1:0] v_pipe;
    logic [RD_LAT-1:0] last_pipe;
    logic [1:0]       sel_pipe [RD_LAT];
    logic [D_W-1:0]   rd_word;
    logic [1:0]       bank;
    logic             accept;
    logic [15:0]      drop_cnt;

    // The FHT expects the bank index of each quarter frame bit-reversed.
    assign bank         = {s[A_W], s[A_W+1]};
    assign accept       = iS_VALID && oS_READY && (state == S_LOAD);
    assign oFHT_ADDR_RD = r[A_W-1:0];
    assign oBUSY        = (state != S_LOAD);

    always_comb begin
        rd_word = iFHT_DATA_0;
        case (sel_pipe[RD_LAT-1])
            2'd1:    rd_word = iFHT_DATA_1;
            2'd2:    rd_word = iFHT_DATA_2;
            2'd3:    rd_word = iFHT_DATA_3;
            default: rd_word = iFHT_DATA_0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state        <= S_LOAD;
            s            <= '0;
            r            <= '0;
            guard_cnt    <= '0;
            v_pipe       <= '0;
            last_pipe    <= '0;
            for (int k = 0; k < RD_LAT; k++) sel_pipe[k] <= '0;
            oS_READY     <= 1'b1;
            oFHT_DATA    <= '0;
            oFHT_ADDR_WR <= '0;
            oFHT_WE      <= '0;
            oFHT_START   <= 1'b0;
            oM_DATA      <= '0;
            oM_VALID     <= 1'b0;
            oM_LAST      <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            oFHT_WE    <= '0;
            oFHT_START <= 1'b0;

            // Bank select, valid and last travel alongside the RAM read latency.
            v_pipe[0]    <= (state == S_READ);
            last_pipe[0] <= (state == S_READ) && (r == LOG_N'(N-1));
            sel_pipe[0]  <= r[LOG_N-1:A_W];
            for (int k = 1; k < RD_LAT; k++) begin
                v_pipe[k]    <= v_pipe[k-1];
                last_pipe[k] <= last_pipe[k-1];
                sel_pipe[k]  <= sel_pipe[k-1];
            end
            oM_VALID <= v_pipe[RD_LAT-1];
            oM_LAST  <= last_pipe[RD_LAT-1];
            if (v_pipe[RD_LAT-1]) oM_DATA <= rd_word;

            if (DROP_EN && iS_VALID && (state != S_LOAD) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            case (state)
                S_LOAD: begin
                    if (accept) begin
                        oFHT_DATA    <= iS_DATA;
                        oFHT_ADDR_WR <= s[A_W-1:0];
                        oFHT_WE      <= 4'b0001 << bank;
                        if (s == LOG_N'(N-1)) begin
                            s          <= '0;
                            oFHT_START <= 1'b1;
                            oS_READY   <= DROP_EN;
                            drop_cnt   <= '0;
                            state      <= S_START;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                S_START: begin
                    guard_cnt <= 8'(GUARD - 1);
                    state     <= S_GUARD;
                end
                S_GUARD: begin
                    if (guard_cnt == '0) state <= S_WAIT;
                    else guard_cnt <= guard_cnt - 8'd1;
                end
                S_WAIT: begin
                    if (iFHT_RDY) begin
                        r     <= '0;
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (r == LOG_N'(N-1)) begin
                        r     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (oM_LAST) begin
                        oS_READY <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef FHT_FRAME_DROP_EN
    assign oDROP_CNT = drop_cnt;
`endif

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// Self-checking bench for fht_frame_ctrl: write and read scoreboards plus timing sequences.
// Covers FHT_FRAME_DROP_EN when that macro is defined for both files.
module tb_fht_frame_ctrl;
    localparam int N = 1024, A_W = 8, D_W = 16, RD_LAT = 2, GUARD = 2;
`ifdef FHT_FRAME_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [D_W-2:0] s_data;
    logic s_valid, s_ready, fht_start, fht_rdy, m_valid, m_last, busy;
    logic [D_W-2:0] fht_data;
    logic [A_W-1:0] addr_wr, addr_rd;
    logic [3:0] fht_we;
    logic [D_W-1:0] d0, d1, d2, d3, m_data;
    logic [D_W-1:0] p1 [4];
    logic [D_W-1:0] p2 [4];
`ifdef FHT_FRAME_DROP_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    fht_frame_ctrl #(.N(N), .A_W(A_W), .D_W(D_W), .RD_LAT(RD_LAT), .GUARD(GUARD)) dut (
        .iCLK(clk), .iRESET(rst_n), .iS_DATA(s_data), .iS_VALID(s_valid), .oS_READY(s_ready),
        .oFHT_DATA(fht_data), .oFHT_ADDR_WR(addr_wr), .oFHT_WE(fht_we), .oFHT_START(fht_start),
        .iFHT_RDY(fht_rdy), .oFHT_ADDR_RD(addr_rd),
        .iFHT_DATA_0(d0), .iFHT_DATA_1(d1), .iFHT_DATA_2(d2), .iFHT_DATA_3(d3),
        .oM_DATA(m_data), .oM_VALID(m_valid), .oM_LAST(m_last), .oBUSY(busy)
`ifdef FHT_FRAME_DROP_EN
        , .oDROP_CNT(drop_cnt)
`endif
    );

    // Result RAM model: fixed contents per bank, two-cycle read latency.
    function automatic logic [15:0] ram_val(input int b, input int a);
        return {b[1:0], 6'h2B, a[7:0]};
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            p1[b] <= ram_val(b, int'(addr_rd));
            p2[b] <= p1[b];
        end
    end
    assign d0 = p2[0];
    assign d1 = p2[1];
    assign d2 = p2[2];
    assign d3 = p2[3];

    typedef struct { int lo; int hi; logic [3:0] we; } map_t;
    typedef struct { logic [3:0] we; logic [7:0] addr; logic [14:0] data; logic start; } wr_t;
    typedef struct { logic [15:0] data; logic last; int idx; } rd_t;

    map_t map_tbl [4];
    wr_t  wr_q [$];
    rd_t  rd_q [$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, wr_cnt = 0, start_cnt = 0, rd_seen = 0, first_cyc = 0, last_cyc = 0;
    int bank_cnt [4] = '{0, 0, 0, 0};

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(input string nm, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", nm, what);
    endfunction

    function automatic logic [3:0] exp_we(input int k);
        for (int t = 0; t < 4; t++)
            if (k >= map_tbl[t].lo && k <= map_tbl[t].hi) return map_tbl[t].we;
        return 4'b0000;
    endfunction

    // Monitor: pops write and read scoreboards as the DUT produces them.
    always @(negedge clk) begin
        wr_t e;
        rd_t q;
        cyc++;
        if (rst_n) begin
            if (fht_we != 4'b0000) begin
                wr_cnt++;
                for (int b = 0; b < 4; b++) if (fht_we[b]) bank_cnt[b]++;
                if (wr_q.size() == 0) fail_now("unexpected_we", $sformatf("got we=%b addr=%0d, expected none", fht_we, addr_wr));
                else begin
                    e = wr_q.pop_front();
                    chk("wr_we", {28'h0, fht_we}, {28'h0, e.we});
                    chk("wr_addr", {24'h0, addr_wr}, {24'h0, e.addr});
                    chk("wr_data", {17'h0, fht_data}, {17'h0, e.data});
                    chk("wr_start", {31'h0, fht_start}, {31'h0, e.start});
                end
            end else if (fht_start) begin
                fail_now("start_without_we", "got start=1 with we=0, expected start with last write");
            end
            if (fht_start) start_cnt++;
            if (m_valid) begin
                if (rd_q.size() == 0) fail_now("unexpected_valid", $sformatf("got data=%0h, expected no output", m_data));
                else begin
                    q = rd_q.pop_front();
                    chk("rd_data", {16'h0, m_data}, {16'h0, q.data});
                    chk("rd_last", {31'h0, m_last}, {31'h0, q.last});
                    if (q.idx == 0) first_cyc = cyc;
                    if (q.last) last_cyc = cyc;
                end
                rd_seen++;
            end
        end
    end

    task automatic load_frame(input int period, input int base);
        for (int k = 0; k < N; k++) begin
            for (int g = 1; g < period; g++) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = 15'(base + k);
            wr_q.push_back('{exp_we(k), 8'(k % 256), 15'(base + k), (k == N-1)});
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic push_reads();
        for (int k = 0; k < N; k++)
            rd_q.push_back('{ram_val(k / 256, k % 256), (k == N-1), k});
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {7'h0, s_ready, fht_we, fht_start, m_valid, m_last, busy, addr_wr, addr_rd},
                {7'h0, 1'b1, 24'h0});
        chk({nm, "_data"}, {1'b0, fht_data, m_data}, 32'h0);
`ifdef FHT_FRAME_DROP_EN
        chk({nm, "_drop"}, {16'h0, drop_cnt}, 32'h0);
`endif
    endtask

    task automatic wait_last(input int rd_base, input string nm);
        int n = 0;
        while (!m_last && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!m_last) fail_now({nm, "_timeout"}, "got no oM_LAST within 4000 cycles, expected one");
        @(negedge clk);
        chk({nm, "_s_ready_after_last"}, {31'h0, s_ready}, 32'h1);
        chk({nm, "_busy_after_last"}, {31'h0, busy}, 32'h0);
        chk({nm, "_rd_count"}, rd_seen - rd_base, N);
        chk({nm, "_rd_span"}, last_cyc - first_cyc, N - 1);
    endtask

    initial begin
        int bank_base [4];
        int start_base, wr_base, rd_base, n;

        map_tbl[0] = '{0,   255,  4'b0001};
        map_tbl[1] = '{256, 511,  4'b0100};
        map_tbl[2] = '{512, 767,  4'b0010};
        map_tbl[3] = '{768, 1023, 4'b1000};
        s_valid = 1'b0;
        s_data  = '0;
        fht_rdy = 1'b1;
        rst_n   = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_we", {28'h0, fht_we}, 32'h0);
            chk("idle_ready_busy", {30'h0, s_ready, busy}, 32'h2);
        end

        // Frame A: continuous ramp, samples during WAIT, RDY raised 500 cycles after drop.
        for (int b = 0; b < 4; b++) bank_base[b] = bank_cnt[b];
        start_base = start_cnt;
        load_frame(1, 1);
        chk("a_start_with_last", {31'h0, fht_start}, 32'h1);
        chk("a_s_ready_drop", {31'h0, s_ready}, {31'h0, DROP});
        @(negedge clk);
        fht_rdy = 1'b0;
        for (int t = 0; t < 4; t++)
            chk($sformatf("a_bank%0d_writes", t), bank_cnt[t] - bank_base[t], 256);
        for (int i = 0; i < 500; i++) begin
            s_valid = (i >= 6 && i < 16);
            s_data  = 15'h7ABC;
            @(negedge clk);
            if (i >= 6 && i < 16) chk("wait_s_ready", {31'h0, s_ready}, {31'h0, DROP});
        end
        s_valid = 1'b0;
`ifdef FHT_FRAME_DROP_EN
        chk("drop_cnt_10", {16'h0, drop_cnt}, 32'd10);
`endif
        chk("a_busy_wait", {31'h0, busy}, 32'h1);
        fht_rdy = 1'b1;
        push_reads();
        rd_base = rd_seen;
        @(negedge clk);
        chk("first_rd_addr", {24'h0, addr_rd}, 32'h0);
        chk("valid_not_yet_1", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("valid_not_yet_3", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        chk("valid_latency", {31'h0, m_valid}, 32'h1);
        wait_last(rd_base, "a");
        chk("a_single_start", start_cnt - start_base, 1);

        // Frame B: valid every third cycle, reset mid-read.
        wr_base = wr_cnt;
        load_frame(3, 2000);
        @(negedge clk);
        fht_rdy = 1'b0;
        chk("b_wr_count", wr_cnt - wr_base, N);
`ifdef FHT_FRAME_DROP_EN
        chk("b_drop_cleared", {16'h0, drop_cnt}, 32'h0);
`endif
        repeat (50) @(negedge clk);
        fht_rdy = 1'b1;
        push_reads();
        rd_base = rd_seen;
        n = 0;
        while ((rd_seen - rd_base) < 100 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if ((rd_seen - rd_base) < 100) fail_now("b_read_timeout", "got fewer than 100 words in 300 cycles, expected 100");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        chk_reset("reset_hold_mid");
        rst_n = 1'b1;
        @(negedge clk);

        // Frame C: fresh ramp from bank 0, RDY already high when WAIT is entered.
        wr_base = wr_cnt;
        load_frame(1, 5000);
        chk("c_start_with_last", {31'h0, fht_start}, 32'h1);
        push_reads();
        rd_base = rd_seen;
        repeat (6) @(negedge clk);
        chk("c_guard_no_valid", {31'h0, m_valid}, 32'h0);
        @(negedge clk);
        chk("c_rdy_on_entry_valid", {31'h0, m_valid}, 32'h1);
        wait_last(rd_base, "c");
        chk("c_wr_count", wr_cnt - wr_base, N);
        chk("queues_empty", wr_q.size() + rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test by 1 ms, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
